// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS decode constants, mult/div FSM encoding and operand helpers.
package mips_pkg;
    localparam int XLEN = 32;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX} state_e;

    // 0x8000_0000 negates to itself, which is its correct unsigned magnitude.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic sgn);
        return (sgn && x[XLEN-1]) ? -x : x;
    endfunction
endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: 32-step radix-2 shift-add multiplier / restoring divider on unsigned operands.
module muldiv_iter_core
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              div_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic              finish_o,
    output logic [2*XLEN-1:0] result_o
);
    localparam int CW = $clog2(XLEN);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   m_q, m_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d, div_q, div_d;
    logic [XLEN:0]     sum, r_sh, diff;

    // Multiply keeps the multiplier in the low half and shifts the product in from the top;
    // divide keeps {remainder, dividend/quotient} and shifts left.
    assign sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
    assign r_sh     = acc_q[2*XLEN-1:XLEN-1];
    assign diff     = r_sh - {1'b0, m_q};
    assign finish_o = busy_q && (cnt_q == CW'(XLEN-1));
    assign result_o = acc_q;

    always_comb begin
        acc_d  = acc_q;
        m_d    = m_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        div_d  = div_q;
        if (start_i) begin
            acc_d  = {{XLEN{1'b0}}, div_i ? a_i : b_i};
            m_d    = div_i ? b_i : a_i;
            cnt_d  = '0;
            busy_d = 1'b1;
            div_d  = div_i;
        end else if (busy_q) begin
            acc_d  = div_q ? {(diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0]), acc_q[XLEN-2:0], ~diff[XLEN]}
                           : {sum, acc_q[XLEN-1:1]};
            cnt_d  = cnt_q + CW'(1);
            busy_d = !finish_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            m_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            div_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            m_q    <= m_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            div_q  <= div_d;
        end
    end
endmodule

// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: iterative MIPS mult/div unit owning the architectural HI/LO pair,
// the request handshake, sign fix-up and sticky status flags.
module muldiv_hilo_unit
    import mips_pkg::*;
#(
    parameter int          WIDTH   = XLEN,
    parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] i_datain,
    input  logic [WIDTH-1:0] gr1,
    input  logic [WIDTH-1:0] gr2,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             done,
    output logic             overflow,
    output logic             div_zero,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    state_e             state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, rd_data_q, rd_data_d, dz_hi_q, dz_hi_d;
    logic               rd_valid_q, rd_valid_d, done_q, done_d, illegal_q, illegal_d;
    logic               ovf_q, ovf_d, dz_q, dz_d, div_q, div_d;
    logic               sgn_res_q, sgn_res_d, sgn_rem_q, sgn_rem_d;
    logic [5:0]         opcode, funct;
    logic               accept, is_r, is_mul, is_div, is_sgn, is_mf, is_mt, legal, div0;
    logic               core_start, core_fin;
    logic [2*WIDTH-1:0] raw;
    logic               unused_bits;

    assign opcode      = i_datain[31:26];
    assign funct       = i_datain[5:0];
    assign unused_bits = ^i_datain[25:6];
    assign accept      = in_valid && (state_q == ST_IDLE);
    assign is_r        = (opcode == OP_RTYPE);
    assign is_mul      = is_r && (funct == FN_MULT || funct == FN_MULTU);
    assign is_div      = is_r && (funct == FN_DIV || funct == FN_DIVU);
    assign is_sgn      = (funct == FN_MULT || funct == FN_DIV);
    assign is_mf       = is_r && (funct == FN_MFHI || funct == FN_MFLO);
    assign is_mt       = is_r && (funct == FN_MTHI || funct == FN_MTLO);
    assign legal       = is_mul || is_div || is_mf || is_mt;
    assign div0        = is_div && (gr2 == '0);
    assign core_start  = accept && (is_mul || (is_div && !div0));

    muldiv_iter_core u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (core_start),
        .div_i    (is_div),
        .a_i      (mag(gr1, is_sgn)),
        .b_i      (mag(gr2, is_sgn)),
        .finish_o (core_fin),
        .result_o (raw)
    );

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        rd_data_d  = rd_data_q;
        dz_hi_d    = dz_hi_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        illegal_d  = 1'b0;
        ovf_d      = ovf_q;
        dz_d       = dz_q;
        div_d      = div_q;
        sgn_res_d  = sgn_res_q;
        sgn_rem_d  = sgn_rem_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                illegal_d  = !legal;
                ovf_d      = is_div && is_sgn && gr1 == {1'b1, {(WIDTH-1){1'b0}}} && gr2 == '1;
                dz_d       = div0;
                div_d      = is_div;
                dz_hi_d    = gr1;
                sgn_res_d  = is_sgn && (gr1[WIDTH-1] ^ gr2[WIDTH-1]);
                sgn_rem_d  = is_sgn && gr1[WIDTH-1];
                rd_valid_d = is_mf;
                rd_data_d  = !is_mf ? rd_data_q : (funct == FN_MFHI) ? hi_q : lo_q;
                hi_d       = (is_mt && funct == FN_MTHI) ? gr1 : hi_q;
                lo_d       = (is_mt && funct == FN_MTLO) ? gr1 : lo_q;
                state_d    = div0 ? ST_FIX : (is_mul || is_div) ? ST_CALC : ST_IDLE;
            end
            ST_CALC: state_d = core_fin ? ST_FIX : ST_CALC;
            ST_FIX: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (dz_q) begin
                    hi_d = dz_hi_q;
                    lo_d = DIV0_LO;
                end else if (div_q) begin
                    hi_d = sgn_rem_q ? -raw[2*WIDTH-1:WIDTH] : raw[2*WIDTH-1:WIDTH];
                    lo_d = sgn_res_q ? -raw[WIDTH-1:0] : raw[WIDTH-1:0];
                end else begin
                    {hi_d, lo_d} = sgn_res_q ? -raw : raw;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            rd_data_q  <= '0;
            dz_hi_q    <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
            ovf_q      <= 1'b0;
            dz_q       <= 1'b0;
            div_q      <= 1'b0;
            sgn_res_q  <= 1'b0;
            sgn_rem_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            rd_data_q  <= rd_data_d;
            dz_hi_q    <= dz_hi_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            illegal_q  <= illegal_d;
            ovf_q      <= ovf_d;
            dz_q       <= dz_d;
            div_q      <= div_d;
            sgn_res_q  <= sgn_res_d;
            sgn_rem_q  <= sgn_rem_d;
        end
    end

    assign in_ready = (state_q == ST_IDLE);
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign div_zero = dz_q;
    assign illegal  = illegal_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// tb_muldiv_hilo_unit: directed-vector bench for the mult/div HI/LO unit.
module tb_muldiv_hilo_unit;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
    logic [31:0] i_datain = '0, gr1 = '0, gr2 = '0;
    logic        in_ready, rd_valid, done, overflow, div_zero, illegal;
    logic [31:0] rd_data, hi, lo;
    int          n_cmp = 0, n_bad = 0;

    localparam logic [31:0] W_MFHI = 32'h10, W_MTHI = 32'h11, W_MFLO = 32'h12, W_MTLO = 32'h13;
    localparam logic [31:0] W_MULT = 32'h18, W_MULTU = 32'h19, W_DIV = 32'h1A, W_DIVU = 32'h1B;

    always #5 clk = ~clk;

    muldiv_hilo_unit dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .i_datain(i_datain), .gr1(gr1), .gr2(gr2), .rd_valid(rd_valid), .rd_data(rd_data),
        .done(done), .overflow(overflow), .div_zero(div_zero), .illegal(illegal), .hi(hi), .lo(lo)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single edge; caller guarantees in_ready.
    task automatic issue(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1; i_datain = w; gr1 = a; gr2 = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if ({hi, lo, rd_data} !== 96'h0) begin n_bad++; $display("FAIL reset_regs got hi=%h lo=%h rd=%h exp all 0", hi, lo, rd_data); end
        n_cmp++; if ({in_ready, rd_valid, done, illegal, overflow, div_zero} !== 6'b100000) begin n_bad++; $display("FAIL reset_flags got %b exp 100000", {in_ready, rd_valid, done, illegal, overflow, div_zero}); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        issue(W_MFHI, 32'h0, 32'h0);
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 32'h0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_mfhi got v=%b d=%h rdy=%b exp v=1 d=0 rdy=1", rd_valid, rd_data, in_ready); end
        tick();
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL mfhi_pulse got %b exp 0", rd_valid); end
    endtask

    task automatic test_mult();
        issue(W_MULT, 32'd7, 32'hFFFF_FFFD);
        for (int k = 1; k <= 33; k++) begin
            n_cmp++; if (in_ready !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin n_bad++; $display("FAIL mult_busy cyc=%0d got rdy=%b done=%b hi=%h lo=%h exp 0 0 0 0", k, in_ready, done, hi, lo); end
            tick();
        end
        n_cmp++; if (done !== 1'b1 || in_ready !== 1'b1) begin n_bad++; $display("FAIL mult_done got done=%b rdy=%b exp 1 1", done, in_ready); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin n_bad++; $display("FAIL mult_val got %h_%h exp ffffffff_ffffffeb", hi, lo); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_pulse got %b exp 0", done); end
    endtask

    task automatic test_back_to_back();
        issue(W_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (33) tick();
        n_cmp++; if (done !== 1'b1 || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin n_bad++; $display("FAIL multu got done=%b %h_%h exp 1 fffffffe_00000001", done, hi, lo); end
        issue(W_DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (33) tick();
        n_cmp++; if (done !== 1'b1 || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL b2b_div got done=%b hi=%h lo=%h exp 1 ffffffff fffffffd", done, hi, lo); end
    endtask

    task automatic test_div_zero();
        issue(W_DIVU, 32'd5, 32'd0);
        n_cmp++; if (in_ready !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL dz_busy got rdy=%b done=%b exp 0 0", in_ready, done); end
        tick();
        n_cmp++; if (done !== 1'b1 || in_ready !== 1'b1 || hi !== 32'd5 || lo !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL dz_result got done=%b rdy=%b hi=%h lo=%h exp 1 1 5 ffffffff", done, in_ready, hi, lo); end
        n_cmp++; if (div_zero !== 1'b1 || overflow !== 1'b0) begin n_bad++; $display("FAIL dz_flags got dz=%b ovf=%b exp 1 0", div_zero, overflow); end
        issue(W_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        n_cmp++; if (div_zero !== 1'b0) begin n_bad++; $display("FAIL dz_clear got %b exp 0", div_zero); end
        repeat (33) tick();
        n_cmp++; if (done !== 1'b1 || lo !== 32'h8000_0000 || hi !== 32'h0) begin n_bad++; $display("FAIL ovf_result got done=%b hi=%h lo=%h exp 1 0 80000000", done, hi, lo); end
        n_cmp++; if (overflow !== 1'b1 || div_zero !== 1'b0) begin n_bad++; $display("FAIL ovf_flags got ovf=%b dz=%b exp 1 0", overflow, div_zero); end
    endtask

    task automatic test_mthi_while_busy();
        issue(W_MULT, 32'd3, 32'd5);
        in_valid = 1'b1; i_datain = W_MTHI; gr1 = 32'h1234_5678; gr2 = 32'h0;
        for (int k = 1; k <= 33; k++) begin
            n_cmp++; if (hi !== 32'h0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL mthi_held cyc=%0d got hi=%h rdy=%b exp 0 0", k, hi, in_ready); end
            tick();
        end
        n_cmp++; if (done !== 1'b1 || hi !== 32'h0 || lo !== 32'd15) begin n_bad++; $display("FAIL mthi_mult got done=%b hi=%h lo=%h exp 1 0 f", done, hi, lo); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (hi !== 32'h1234_5678 || in_ready !== 1'b1) begin n_bad++; $display("FAIL mthi_write got hi=%h rdy=%b exp 12345678 1", hi, in_ready); end
        issue(W_MFHI, 32'h0, 32'h0);
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 32'h1234_5678) begin n_bad++; $display("FAIL mthi_mfhi got v=%b d=%h exp 1 12345678", rd_valid, rd_data); end
    endtask

    task automatic test_ops_table();
        logic [31:0] tw[5] = '{W_MULT, W_DIV, W_DIVU, W_MULTU, W_DIV};
        logic [31:0] ta[5] = '{32'h8000_0000, 32'hFFFF_FFF9, 32'd100, 32'h1234_5678, 32'd7};
        logic [31:0] tb[5] = '{32'h8000_0000, 32'hFFFF_FFFE, 32'd7, 32'h10, 32'hFFFF_FFFE};
        logic [31:0] th[5] = '{32'h4000_0000, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'd1};
        logic [31:0] tl[5] = '{32'h0, 32'd3, 32'd14, 32'h2345_6780, 32'hFFFF_FFFD};
        for (int i = 0; i < 5; i++) begin
            issue(tw[i], ta[i], tb[i]);
            repeat (33) tick();
            n_cmp++; if (done !== 1'b1 || hi !== th[i] || lo !== tl[i]) begin n_bad++; $display("FAIL op_table[%0d] got done=%b %h_%h exp 1 %h_%h", i, done, hi, lo, th[i], tl[i]); end
        end
    endtask

    task automatic test_reset_mid_op();
        issue(W_MTLO, 32'hAA, 32'h0);
        n_cmp++; if (lo !== 32'hAA) begin n_bad++; $display("FAIL mtlo got %h exp aa", lo); end
        issue(W_MULT, 32'hFFFF, 32'hFFFF);
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (hi !== 32'h0 || lo !== 32'h0 || in_ready !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL async_rst got hi=%h lo=%h rdy=%b done=%b exp 0 0 1 0", hi, lo, in_ready, done); end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            n_cmp++; if (done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin n_bad++; $display("FAIL rst_abort cyc=%0d got done=%b hi=%h lo=%h exp 0 0 0", k, done, hi, lo); end
            tick();
        end
        issue(W_MTHI, 32'h55, 32'h0);
        issue(W_MTLO, 32'h66, 32'h0);
        issue(32'h0000_003F, 32'h1, 32'h2);
        n_cmp++; if (illegal !== 1'b1 || hi !== 32'h55 || lo !== 32'h66) begin n_bad++; $display("FAIL illegal got ill=%b hi=%h lo=%h exp 1 55 66", illegal, hi, lo); end
        n_cmp++; if (in_ready !== 1'b1 || done !== 1'b0 || rd_valid !== 1'b0) begin n_bad++; $display("FAIL illegal_side got rdy=%b done=%b v=%b exp 1 0 0", in_ready, done, rd_valid); end
        tick();
        n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL illegal_pulse got %b exp 0", illegal); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_back_to_back();
        test_div_zero();
        test_mthi_while_busy();
        test_ops_table();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
Multi-cycle multiply/divide unit and architectural HI/LO register pair for the single-issue MIPS datapath. Takes the same instruction word and gr1/gr2 operands that the main ALU receives. Executes mult/multu/div/divu iteratively, and services mfhi/mflo/mthi/mtlo. Replaces the combinational hi/lo path; results feed the writeback mux.

Parameters:
WIDTH, 32, operand/HI/LO width; the only supported value is 32.
DIV0_LO, 32'hFFFF_FFFF, LO value written on divide-by-zero.

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request present
in_ready  out  1  unit can accept a request this cycle
i_datain  in  32  instruction word; opcode [31:26], funct [5:0]
gr1  in  32  rs operand
gr2  in  32  rt operand
rd_valid  out  1  one-cycle pulse: rd_data is valid (mfhi/mflo)
rd_data  out  32  HI or LO for mfhi/mflo
done  out  1  one-cycle pulse: mult/div finished, HI/LO updated
overflow  out  1  sticky until next accepted op; set by div 0x8000_0000 / -1
div_zero  out  1  sticky until next accepted op; set by div/divu with gr2 == 0
illegal  out  1  one-cycle pulse: accepted word is not a supported op
hi  out  32  architectural HI
lo  out  32  architectural LO

Behaviour:
- Reset (async, rst_n low): state=IDLE, hi=lo=0, in_ready=1, rd_valid=done=illegal=0, overflow=div_zero=0, rd_data=0. Reset mid-operation aborts with no partial HI/LO update.
- Handshake: a request is accepted on the edge where in_valid && in_ready. in_ready = (state==IDLE). Inputs are sampled only at acceptance.
- Decode: valid only when opcode==0 and funct in {18 mult, 19 multu, 1a div, 1b divu, 10 mfhi, 12 mflo, 11 mthi, 13 mtlo}. Any other word is accepted, raises illegal, and changes nothing else.
- Single-cycle ops (stay in IDLE):
  - mfhi/mflo: rd_data <= hi/lo and rd_valid pulses in the cycle after acceptance.
  - mthi/mtlo: hi/lo <= gr1 on the accepting edge.
- Iterative ops, FSM IDLE -> CALC -> FIX -> IDLE:
  - Accept: latch |gr1|, |gr2| (signed ops) or raw values (unsigned ops); record result signs; iter counter=0.
  - CALC, exactly 32 cycles, one bit per cycle:
    - multiply: shift-add radix-2 into a 64-bit accumulator.
    - divide: restoring division with 33-bit remainder subtract.
  - FIX, 1 cycle: apply sign correction, then write hi/lo and pulse done.
    - mult: {hi,lo} = 64-bit product.
    - div: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
  - Total latency: done asserts 34 cycles after the accepting edge. in_ready returns to 1 in the same cycle done pulses; back-to-back issue is legal.
- Boundary cases:
  - Divide by zero: detected at accept; CALC is skipped (IDLE -> FIX). hi = gr1, lo = DIV0_LO, div_zero=1; done pulses 2 cycles after accept.
  - div 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0, overflow=1, full latency.
  - Magnitude of 0x8000_0000 is handled as unsigned 33-bit; no internal overflow.
- hi/lo are visible continuously. During CALC, hi/lo keep their old values; intermediate state lives in private registers only.

Decomposition:
- Shared package mips_pkg: funct constants (FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MFHI, FN_MFLO, FN_MTHI, FN_MTLO), OP_RTYPE, and the FSM state encoding.
- One natural sub-module, muldiv_iter_core: holds the 32-cycle shift/accumulate datapath and iteration counter. It has a start/mode input and exposes a raw 64-bit result with a finish strobe. The top level owns the handshake, sign fix-up, HI/LO and flags.

Test Plan:
- Reset release, then mfhi -> rd_valid 1 cycle later with rd_data=0; in_ready=1.
- mult 7 * 0xFFFF_FFFD -> done at +34 cycles; hi=0xFFFF_FFFF, lo=0xFFFF_FFEB; in_ready low for cycles +1..+33.
- multu 0xFFFF_FFFF * 0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001. Immediate back-to-back div 0xFFFF_FFF9 / 2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
- divu 5 / 0 -> done at +2; hi=5, lo=0xFFFF_FFFF, div_zero=1. Then div 0x8000_0000 / 0xFFFF_FFFF -> lo=0x8000_0000, hi=0, overflow=1, div_zero=0.
- mthi 0x1234_5678 while in_valid held during a busy mult -> not accepted until in_ready. After mult done, hi=0x1234_5678 on the following edge and mfhi returns it.
- rst_n low at cycle 10 of a mult (after mtlo 0xAA) -> hi=lo=0 immediately, state IDLE; illegal word 0x0000_003F -> illegal pulse, hi/lo unchanged.
